// File: rtl/natv_timer.sv
// natv_timer: native valid/ready bus responder with a 32-bit prescaled timer,
// compare match and a level interrupt. Every access takes exactly one wait state.
// Optional feature macro: NATV_TIMER_IRQ_EN. When it is defined, CTRL[1] (IRQ_EN)
// exists and irq_o = MATCH & IRQ_EN. When it is undefined, CTRL[1] reads 0 and
// irq_o is tied low.
module natv_timer #(
  parameter int PSCR_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wstrb_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ready_o,
  output logic        irq_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  localparam logic [2:0] A_CTRL = 3'd0;
  localparam logic [2:0] A_PSCR = 3'd1;
  localparam logic [2:0] A_CNT  = 3'd2;
  localparam logic [2:0] A_CMP  = 3'd3;
  localparam logic [2:0] A_STAT = 3'd4;

  logic [0:0]        state;
  logic              ctrl_en;
  logic              ctrl_auto;
  logic              irq_en_rd;
  logic [PSCR_W-1:0] pscr;
  logic [PSCR_W-1:0] pcnt;
  logic [31:0]       cnt;
  logic [31:0]       cmp;
  logic              match;

  logic              accept;
  logic              wr;
  logic [2:0]        sel;
  logic              tick;
  logic              hit;
  logic [31:0]       rd_mux;
  logic              unused_addr;

  // Replace only the byte lanes selected by the write strobes.
  function automatic logic [31:0] lane_merge(input logic [31:0] cur,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

  assign accept      = (state == ST_IDLE) && mem_valid_i;
  assign wr          = accept && (mem_wstrb_i != 4'b0000);
  assign sel         = mem_addr_i[4:2];
  assign tick        = ctrl_en && (pcnt == pscr);
  assign hit         = (cnt == cmp);
  assign unused_addr = ^{mem_addr_i[31:5], mem_addr_i[1:0]};

`ifdef NATV_TIMER_IRQ_EN
  logic ctrl_irq_en;

  // IRQ_EN bit of CTRL, lane 0 only.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl_irq_en <= 1'b0;
    end else if (wr && (sel == A_CTRL) && mem_wstrb_i[0]) begin
      ctrl_irq_en <= mem_wdata_i[1];
    end
  end

  assign irq_en_rd = ctrl_irq_en;
  assign irq_o     = match & ctrl_irq_en;
`else
  assign irq_en_rd = 1'b0;
  assign irq_o     = 1'b0;
`endif

  // Bus handshake: accept in IDLE, answer with a one-cycle ready pulse in RESP.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      mem_ready_o <= 1'b0;
      mem_rdata_o <= 32'd0;
    end else begin
      mem_ready_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mem_valid_i) begin
            state       <= ST_RESP;
            mem_ready_o <= 1'b1;
            mem_rdata_o <= wr ? 32'd0 : rd_mux;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read mux samples register values before this cycle's update.
  always_comb begin
    rd_mux = 32'd0;
    case (sel)
      A_CTRL: rd_mux = {29'd0, ctrl_auto, irq_en_rd, ctrl_en};
      A_PSCR: rd_mux = 32'(pscr);
      A_CNT:  rd_mux = cnt;
      A_CMP:  rd_mux = cmp;
      A_STAT: rd_mux = {31'd0, match};
      default: rd_mux = 32'd0;
    endcase
  end

  // CTRL EN / AUTO_RELOAD bits, lane 0 only.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl_en   <= 1'b0;
      ctrl_auto <= 1'b0;
    end else if (wr && (sel == A_CTRL) && mem_wstrb_i[0]) begin
      ctrl_en   <= mem_wdata_i[0];
      ctrl_auto <= mem_wdata_i[2];
    end
  end

  // Prescaler divisor register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pscr <= '0;
    end else if (wr && (sel == A_PSCR)) begin
      pscr <= PSCR_W'(lane_merge(32'(pscr), mem_wdata_i, mem_wstrb_i));
    end
  end

  // Prescaler counter: held at 0 when disabled, restarted by any PSCR write.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pcnt <= '0;
    end else if ((wr && (sel == A_PSCR)) || !ctrl_en || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PSCR_W'(1);
    end
  end

  // Main counter: a bus write takes priority over the tick update.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt <= 32'd0;
    end else if (wr && (sel == A_CNT)) begin
      cnt <= lane_merge(cnt, mem_wdata_i, mem_wstrb_i);
    end else if (tick) begin
      cnt <= (hit && ctrl_auto) ? 32'd0 : cnt + 32'd1;
    end
  end

  // Compare register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cmp <= 32'd0;
    end else if (wr && (sel == A_CMP)) begin
      cmp <= lane_merge(cmp, mem_wdata_i, mem_wstrb_i);
    end
  end

  // MATCH flag: set on a matching tick, which beats a same-cycle clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      match <= 1'b0;
    end else if (tick && hit) begin
      match <= 1'b1;
    end else if (wr && (sel == A_STAT) && mem_wstrb_i[0] && mem_wdata_i[0]) begin
      match <= 1'b0;
    end
  end

endmodule

// File: tb/tb_natv_timer.sv
// Testbench for natv_timer: randomized bus traffic checked against an
// arithmetic reference model of the timer.
module tb_natv_timer;

  localparam int          PSCR_W    = 16;
  localparam logic [31:0] PSCR_MASK = 32'h0000_FFFF;

`ifdef NATV_TIMER_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        mem_valid_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_wstrb_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ready_o;
  logic        irq_o;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] model [0:7];
  logic [31:0] cmp_shadow;

  natv_timer #(.PSCR_W(PSCR_W)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .mem_valid_i (mem_valid_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_wstrb_i (mem_wstrb_i),
    .mem_rdata_o (mem_rdata_o),
    .mem_ready_o (mem_ready_o),
    .irq_o       (irq_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // One bus access; acc is the cycle number of the accepting edge.
  task automatic bus_xfer(input logic [2:0] off, input logic [31:0] wd,
                          input logic [3:0] ws, output logic [31:0] rd,
                          output int lat, output int acc);
    logic [31:0] a;
    a = $urandom();
    a[4:2] = off;
    mem_valid_i = 1'b1;
    mem_addr_i  = a;
    mem_wdata_i = wd;
    mem_wstrb_i = ws;
    lat = 0;
    acc = -1;
    rd  = 32'hDEAD_BEEF;
    while (lat < 8) begin
      @(posedge clk_i); #1;
      lat++;
      if (mem_ready_o) begin
        rd  = mem_rdata_o;
        acc = cyc;
        break;
      end
    end
    mem_valid_i = 1'b0;
    mem_wstrb_i = 4'b0000;
    if (acc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL bus_timeout off=%0d: no ready within %0d cycles, required ready", off, lat);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic wr_reg(input logic [2:0] off, input logic [31:0] wd, output int acc);
    logic [31:0] d;
    int lat;
    bus_xfer(off, wd, 4'hF, d, lat, acc);
  endtask

  task automatic rd_reg(input logic [2:0] off, output logic [31:0] d, output int acc);
    int lat;
    bus_xfer(off, 32'd0, 4'h0, d, lat, acc);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int lat, acc;
    rst_n_i     = 1'b0;
    mem_valid_i = 1'b0;
    mem_addr_i  = 32'd0;
    mem_wdata_i = 32'd0;
    mem_wstrb_i = 4'd0;
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++;
    if ({mem_ready_o, irq_o, mem_rdata_o} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b irq=%b rdata=%h, required all 0",
               mem_ready_o, irq_o, mem_rdata_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_xfer(3'(i), 32'd0, 4'd0, d, lat, acc);
      n_checks++;
      if (d !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_read off=%0d: got %h, required 0", i, d);
      end
      n_checks++;
      if (lat !== 1) begin
        n_fail++;
        $display("FAIL reset_latency off=%0d: got %0d, required 1", i, lat);
      end
      n_checks++;
      if (mem_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL ready_width off=%0d: ready still %b one cycle later, required 0", i, mem_ready_o);
      end
      n_checks++;
      if (irq_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_irq off=%0d: got %b, required 0", i, irq_o);
      end
    end
    for (int i = 0; i < 8; i++) model[i] = 32'd0;
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d, wd, expv;
    logic [3:0]  ws;
    logic [2:0]  off;
    int lat, acc;
    int offs [6] = '{1, 2, 3, 5, 6, 7};
    bus_xfer(3'd3, 32'h1234_5678, 4'b0101, d, lat, acc);
    model[3] = 32'h0034_0078;
    rd_reg(3'd3, d, acc);
    n_checks++;
    if (d !== 32'h0034_0078) begin
      n_fail++;
      $display("FAIL cmp_strobe: got %h, required 00340078", d);
    end
    for (int it = 0; it < 10; it++) begin
      off = 3'(offs[$urandom_range(0, 5)]);
      wd  = $urandom();
      ws  = 4'($urandom_range(1, 15));
      bus_xfer(off, wd, ws, d, lat, acc);
      n_checks++;
      if (d !== 32'd0) begin
        n_fail++;
        $display("FAIL write_rdata off=%0d: got %h, required 0", off, d);
      end
      for (int b = 0; b < 4; b++)
        if (ws[b]) model[off][8*b +: 8] = wd[8*b +: 8];
      if (off == 3'd1) model[off] = model[off] & PSCR_MASK;
      if (off >= 3'd5) model[off] = 32'd0;
      rd_reg(off, d, acc);
      n_checks++;
      if (d !== model[off]) begin
        n_fail++;
        $display("FAIL lane_readback off=%0d ws=%b: got %h, required %h", off, ws, d, model[off]);
      end
    end
    wr_reg(3'd0, 32'hFFFF_FFFE, acc);
    rd_reg(3'd0, d, acc);
    expv = HAS_IRQ ? 32'h6 : 32'h4;
    n_checks++;
    if (d !== expv) begin
      n_fail++;
      $display("FAIL ctrl_bits: got %h, required %h", d, expv);
    end
    wr_reg(3'd0, 32'd0, acc);
  endtask

  task automatic test_counting();
    logic [31:0] d, expv;
    int p, nw, nr, acc;
    for (int it = 0; it < 5; it++) begin
      p = (it == 0) ? 3 : int'($urandom_range(0, 4));
      wr_reg(3'd0, 32'd0, acc);
      wr_reg(3'd1, 32'(p), acc);
      wr_reg(3'd2, 32'd0, acc);
      wr_reg(3'd3, 32'hFFFF_0000, acc);
      wr_reg(3'd0, 32'd1, nw);
      repeat ((it == 0) ? 40 : int'($urandom_range(3, 40))) @(posedge clk_i);
      #1;
      rd_reg(3'd2, d, nr);
      expv = 32'((nr - 1 - nw) / (p + 1));
      n_checks++;
      if (d !== expv) begin
        n_fail++;
        $display("FAIL count pscr=%0d: got %0d, required %0d", p, d, expv);
      end
    end
    wr_reg(3'd0, 32'd0, acc);
  endtask

  task automatic test_match();
    logic [31:0] d, expv;
    int c, nw, nr, acc, first, high_cnt;
    c = int'($urandom_range(3, 10));
    wr_reg(3'd0, 32'd0, acc);
    wr_reg(3'd4, 32'd1, acc);
    wr_reg(3'd1, 32'd0, acc);
    wr_reg(3'd2, 32'd0, acc);
    wr_reg(3'd3, 32'(c), acc);
    wr_reg(3'd0, 32'd7, nw);
    first = -1;
    high_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (irq_o === 1'b1) begin
        high_cnt++;
        if (first < 0) first = cyc;
      end
      @(posedge clk_i); #1;
    end
    if (HAS_IRQ) begin
      n_checks++;
      if (first !== nw + c + 1) begin
        n_fail++;
        $display("FAIL irq_rise cmp=%0d: got edge %0d, required %0d", c, first, nw + c + 1);
      end
    end else begin
      n_checks++;
      if (high_cnt !== 0) begin
        n_fail++;
        $display("FAIL irq_tied: got %0d high cycles, required 0", high_cnt);
      end
    end
    rd_reg(3'd2, d, nr);
    expv = 32'((nr - 1 - nw) % (c + 1));
    n_checks++;
    if (d !== expv) begin
      n_fail++;
      $display("FAIL reload_cnt cmp=%0d: got %0d, required %0d", c, d, expv);
    end
    rd_reg(3'd4, d, acc);
    n_checks++;
    if (d !== 32'd1) begin
      n_fail++;
      $display("FAIL stat_set: got %h, required 1", d);
    end
    rd_reg(3'd0, d, acc);
    expv = HAS_IRQ ? 32'h7 : 32'h5;
    n_checks++;
    if (d !== expv) begin
      n_fail++;
      $display("FAIL ctrl_read: got %h, required %h", d, expv);
    end
    wr_reg(3'd0, 32'd6, acc);
    n_checks++;
    if (irq_o !== HAS_IRQ) begin
      n_fail++;
      $display("FAIL irq_level: got %b, required %b", irq_o, HAS_IRQ);
    end
    wr_reg(3'd4, 32'd1, acc);
    rd_reg(3'd4, d, acc);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL stat_clear: got %h, required 0", d);
    end
    n_checks++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear: got %b, required 0", irq_o);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d, expv;
    int nw, nr, acc;
    wr_reg(3'd0, 32'd0, acc);
    wr_reg(3'd4, 32'd1, acc);
    cmp_shadow = 32'($urandom_range(32'h0001_0000, 32'h7FFF_FFFF));
    wr_reg(3'd3, cmp_shadow, acc);
    wr_reg(3'd1, 32'd0, acc);
    wr_reg(3'd2, 32'hFFFF_FFFF, acc);
    wr_reg(3'd0, 32'd1, nw);
    rd_reg(3'd2, d, nr);
    expv = 32'hFFFF_FFFF + 32'(nr - 1 - nw);
    n_checks++;
    if (d !== expv) begin
      n_fail++;
      $display("FAIL wrap_cnt: got %h, required %h", d, expv);
    end
    rd_reg(3'd4, d, acc);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL wrap_nomatch: got %h, required 0", d);
    end
  endtask

  task automatic test_cnt_tick_write();
    logic [31:0] d, v, expv;
    int nw, nr;
    for (int it = 0; it < 3; it++) begin
      v = (it == 0) ? 32'h100 : 32'h100 + 32'($urandom_range(0, 1000));
      wr_reg(3'd2, v, nw);
      repeat ($urandom_range(0, 5)) @(posedge clk_i);
      #1;
      rd_reg(3'd2, d, nr);
      expv = v + 32'(nr - 1 - nw);
      n_checks++;
      if (d !== expv) begin
        n_fail++;
        $display("FAIL tick_write v=%h: got %h, required %h", v, d, expv);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses, consec;
    logic prev;
    logic [31:0] a;
    pulses = 0;
    consec = 0;
    prev = 1'b0;
    a = $urandom();
    a[4:2] = 3'd3;
    mem_addr_i  = a;
    mem_wstrb_i = 4'd0;
    mem_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i); #1;
      if (mem_ready_o) begin
        pulses++;
        if (prev) consec++;
        n_checks++;
        if (mem_rdata_o !== cmp_shadow) begin
          n_fail++;
          $display("FAIL b2b_data: got %h, required %h", mem_rdata_o, cmp_shadow);
        end
      end
      prev = mem_ready_o;
    end
    mem_valid_i = 1'b0;
    @(posedge clk_i); #1;
    n_checks++;
    if (pulses !== 10) begin
      n_fail++;
      $display("FAIL b2b_rate: got %0d ready pulses, required 10", pulses);
    end
    n_checks++;
    if (consec !== 0) begin
      n_fail++;
      $display("FAIL b2b_gap: got %0d adjacent ready cycles, required 0", consec);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int acc;
    mem_addr_i  = 32'h0000_000C;
    mem_wstrb_i = 4'd0;
    mem_valid_i = 1'b1;
    @(posedge clk_i); #1;
    n_checks++;
    if (mem_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_resp: got ready=%b, required 1", mem_ready_o);
    end
    rst_n_i = 1'b0;
    #1;
    n_checks++;
    if ({mem_ready_o, irq_o, mem_rdata_o} !== 34'd0) begin
      n_fail++;
      $display("FAIL mid_abort: got ready=%b irq=%b rdata=%h, required all 0",
               mem_ready_o, irq_o, mem_rdata_o);
    end
    mem_valid_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_reg(3'(i), d, acc);
      n_checks++;
      if (d !== 32'd0) begin
        n_fail++;
        $display("FAIL mid_regs off=%0d: got %h, required 0", i, d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_counting();
    test_match();
    test_wrap();
    test_cnt_tick_write();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
